// File: rtl/pulse_burst_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_burst_sched_pkg
//  Description : Shared types and helpers for the pulse burst scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package pulse_burst_sched_pkg;

   // Scheduler FSM states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      RUN   = 2'd2,
      GAP   = 2'd3
   } state_e;

   // A zero or over-range burst length means "longest burst"
   function automatic logic [31:0] clamp_len(input logic [31:0] raw,
                                             input logic [31:0] max_len);
      logic [31:0] res;
      res = raw;
      if (raw == 32'd0 || raw > max_len) begin
         res = max_len;
      end
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_burst_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_burst_sched_rr_arbiter
//  Description : Combinational round-robin pick. Scans requesters starting at
//                ptr and wrapping, returns the first active one as one-hot
//                and as an encoded index.
//  Revision    : 1.0 - initial release
// ============================================================================
module pulse_burst_sched_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IW      = $clog2(NUM_REQ)
)(
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      ptr,
   output logic [NUM_REQ-1:0] winner_oh,
   output logic [IW-1:0]      winner_idx
);

   logic          found;
   logic [IW-1:0] k;

   // First active requester at or after ptr, wrapping around
   always_comb begin
      winner_oh  = '0;
      winner_idx = '0;
      found      = 1'b0;
      k          = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         k = IW'((int'(ptr) + i) % NUM_REQ);
         if (!found && req[k]) begin
            found         = 1'b1;
            winner_oh[k]  = 1'b1;
            winner_idx    = k;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/pulse_burst_sched.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_burst_sched
//  Description : Round-robin scheduler sharing one pulse-burst engine among
//                NUM_REQ requesters. Grants one requester, runs a burst of the
//                latched length with a divided square wave, then holds an
//                idle gap before the next grant.
//                Optional feature macro: PULSE_BURST_SCHED_ABORT_EN adds an
//                abort input that ends a running burst early.
//  Revision    : 1.0 - initial release
// ============================================================================
module pulse_burst_sched
   import pulse_burst_sched_pkg::*;
#(
   parameter  int NUM_REQ       = 4,
   parameter  int COUNT_MAX_VAL = 16,
   parameter  int DIV_RATIO     = 4,
   parameter  int GAP_CYCLES    = 2,
   localparam int LW            = $clog2(COUNT_MAX_VAL + 1),
   localparam int IW            = $clog2(NUM_REQ)
)(
   input  logic                  clk,
   input  logic                  rstn,
`ifdef PULSE_BURST_SCHED_ABORT_EN
   input  logic                  abort,
`endif
   input  logic [NUM_REQ-1:0]    req,
   input  logic [NUM_REQ*LW-1:0] len,
   output logic [NUM_REQ-1:0]    gnt,
   output logic                  busy,
   output logic [IW-1:0]         owner,
   output logic                  out_pulse,
   output logic                  done
);

   // Gap counter only needs to reach GAP_CYCLES-1
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   state_e               state, state_d;
   logic [LW-1:0]        count, count_d;
   logic [LW-1:0]        len_q, len_d;
   logic [GW-1:0]        gap_cnt, gap_d;
   logic [IW-1:0]        rr_ptr, rr_d;
   logic [IW-1:0]        owner_d;
   logic [NUM_REQ-1:0]   gnt_d;
   logic                 done_d;
   logic [NUM_REQ-1:0]   win_oh;
   logic [IW-1:0]        win_idx;
   logic [LW-1:0]        len_sel;
   logic                 abort_hit;

`ifdef PULSE_BURST_SCHED_ABORT_EN
   assign abort_hit = abort;
`else
   assign abort_hit = 1'b0;
`endif

   pulse_burst_sched_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_rr_arbiter (
      .req        (req),
      .ptr        (rr_ptr),
      .winner_oh  (win_oh),
      .winner_idx (win_idx)
   );

   // Select the granted requester's length field
   always_comb begin
      len_sel = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (owner == IW'(i)) begin
            len_sel = len[i*LW +: LW];
         end
      end
   end

   // Next-state and datapath update for the scheduler FSM
   always_comb begin
      state_d = state;
      count_d = count;
      len_d   = len_q;
      gap_d   = gap_cnt;
      rr_d    = rr_ptr;
      owner_d = owner;
      gnt_d   = '0;
      done_d  = 1'b0;
      case (state)
         IDLE: begin
            if (|req) begin
               state_d = GRANT;
               owner_d = win_idx;
               gnt_d   = win_oh;
            end
         end
         GRANT: begin
            len_d   = LW'(clamp_len(32'(len_sel), 32'(COUNT_MAX_VAL)));
            rr_d    = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + IW'(1);
            count_d = '0;
            state_d = RUN;
         end
         RUN: begin
            if (count == len_q - LW'(1) || abort_hit) begin
               count_d = '0;
               gap_d   = '0;
               done_d  = 1'b1;
               state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
            end else begin
               count_d = count + LW'(1);
            end
         end
         GAP: begin
            if (int'(gap_cnt) >= GAP_CYCLES - 1) begin
               state_d = IDLE;
            end else begin
               gap_d = gap_cnt + GW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers, cleared asynchronously
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= IDLE;
         count   <= '0;
         len_q   <= '0;
         gap_cnt <= '0;
         rr_ptr  <= '0;
         owner   <= '0;
         gnt     <= '0;
         done    <= 1'b0;
      end else begin
         state   <= state_d;
         count   <= count_d;
         len_q   <= len_d;
         gap_cnt <= gap_d;
         rr_ptr  <= rr_d;
         owner   <= owner_d;
         gnt     <= gnt_d;
         done    <= done_d;
      end
   end

   assign busy      = (state != IDLE);
   assign out_pulse = (state == RUN) && (((32'(count) / DIV_RATIO) % 2) == 1);

endmodule
`default_nettype wire

// File: tb/tb_pulse_burst_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pulse_burst_sched
//  Description : Scoreboard bench for pulse_burst_sched. Stimulus pushes the
//                expected grant and done events; monitors pop and compare
//                whenever the design raises gnt or done. A second instance
//                runs with no idle gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_burst_sched;

   localparam int NR   = 4;
   localparam int CMAX = 16;
   localparam int LW   = $clog2(CMAX + 1);
   localparam int IW   = $clog2(NR);

   typedef struct {
      int idx;
      int cyc;
   } gexp_t;

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic [NR-1:0]    req = '0;
   logic [NR-1:0]    req_b = '0;
   logic [NR*LW-1:0] len = '0;
   logic [NR*LW-1:0] len_b = '0;
`ifdef PULSE_BURST_SCHED_ABORT_EN
   logic             abort = 1'b0;
   logic             abort_b = 1'b0;
`endif

   logic [NR-1:0]    gnt, gnt_b;
   logic             busy, busy_b;
   logic [IW-1:0]    owner, owner_b;
   logic             out_pulse, out_pulse_b;
   logic             done, done_b;

   int               cyc = 0;
   int               checks = 0;
   int               errors = 0;
   gexp_t            gq[$];
   gexp_t            gq_b[$];
   int               dq[$];
   int               dq_b[$];
   gexp_t            ea, eb;
   int               da, db;
   logic [15:0]      pat;

   pulse_burst_sched #(
      .NUM_REQ(NR), .COUNT_MAX_VAL(CMAX), .DIV_RATIO(4), .GAP_CYCLES(2)
   ) dut (
      .clk(clk), .rstn(rstn),
`ifdef PULSE_BURST_SCHED_ABORT_EN
      .abort(abort),
`endif
      .req(req), .len(len), .gnt(gnt), .busy(busy), .owner(owner),
      .out_pulse(out_pulse), .done(done)
   );

   pulse_burst_sched #(
      .NUM_REQ(NR), .COUNT_MAX_VAL(CMAX), .DIV_RATIO(4), .GAP_CYCLES(0)
   ) dut_b (
      .clk(clk), .rstn(rstn),
`ifdef PULSE_BURST_SCHED_ABORT_EN
      .abort(abort_b),
`endif
      .req(req_b), .len(len_b), .gnt(gnt_b), .busy(busy_b), .owner(owner_b),
      .out_pulse(out_pulse_b), .done(done_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // Monitor for the main instance: compare each grant and done against the queue
   always @(negedge clk) begin
      if (gnt !== '0) begin
         if (gq.size() == 0) begin
            check("gnt_unexpected", 32'(gnt), 32'd0);
         end else begin
            ea = gq.pop_front();
            check("gnt_onehot", 32'(gnt), 32'd1 << ea.idx);
            check("gnt_cycle", cyc, ea.cyc);
            check("gnt_owner", 32'(owner), ea.idx);
         end
      end
      if (done !== 1'b0) begin
         if (dq.size() == 0) begin
            check("done_unexpected", 32'(done), 32'd0);
         end else begin
            da = dq.pop_front();
            check("done_cycle", cyc, da);
         end
      end
   end

   // Monitor for the zero-gap instance
   always @(negedge clk) begin
      if (gnt_b !== '0) begin
         if (gq_b.size() == 0) begin
            check("b_gnt_unexpected", 32'(gnt_b), 32'd0);
         end else begin
            eb = gq_b.pop_front();
            check("b_gnt_onehot", 32'(gnt_b), 32'd1 << eb.idx);
            check("b_gnt_cycle", cyc, eb.cyc);
            check("b_gnt_owner", 32'(owner_b), eb.idx);
            check("b_gnt_busy", 32'(busy_b), 32'd1);
            check("b_gnt_out_low", 32'(out_pulse_b), 32'd0);
         end
      end
      if (done_b !== 1'b0) begin
         if (dq_b.size() == 0) begin
            check("b_done_unexpected", 32'(done_b), 32'd0);
         end else begin
            db = dq_b.pop_front();
            check("b_done_cycle", cyc, db);
         end
      end
   end

   // One burst from a lone requester; returns on the first IDLE cycle afterwards
   task automatic do_burst(input int idx, input int lval, input int exp_len, input bit wave);
      int    c;
      gexp_t e;
      c = cyc;
      req[idx] = 1'b1;
      len[idx*LW +: LW] = LW'(lval);
      e.idx = idx;
      e.cyc = c + 1;
      gq.push_back(e);
      dq.push_back(c + 2 + exp_len);
      @(negedge clk);
      req[idx] = 1'b0;
      check("grant_out_low", 32'(out_pulse), 32'd0);
      check("grant_busy", 32'(busy), 32'd1);
      for (int k = 0; k < exp_len; k++) begin
         @(negedge clk);
         if (wave) check($sformatf("wave_count%0d", k), 32'(out_pulse), 32'(pat[k]));
      end
      @(negedge clk);
      check("gap_out_low", 32'(out_pulse), 32'd0);
      check("gap_busy", 32'(busy), 32'd1);
      @(negedge clk);
      check("gap2_busy", 32'(busy), 32'd1);
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
   endtask

   initial begin : stim
      int    s;
      gexp_t e;
      pat = 16'hF0F0;
      repeat (2) @(negedge clk);
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_owner", 32'(owner), 32'd0);
      check("rst_out_pulse", 32'(out_pulse), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      rstn = 1'b1;
      @(negedge clk);

      // All four requesting, length 3: grants 0,1,2,3,0 every 7 cycles.
      // Zero-gap instance: req[1] held, back-to-back every 5 cycles.
      s = cyc;
      req = 4'hF;
      len = {NR{LW'(3)}};
      req_b = 4'b0010;
      len_b = {NR{LW'(3)}};
      for (int k = 0; k < 5; k++) begin
         e.idx = k % NR;
         e.cyc = s + 1 + 7 * k;
         gq.push_back(e);
         dq.push_back(s + 5 + 7 * k);
      end
      for (int k = 0; k < 3; k++) begin
         e.idx = 1;
         e.cyc = s + 1 + 5 * k;
         gq_b.push_back(e);
         dq_b.push_back(s + 5 + 5 * k);
      end
      wait_until(s + 11);
      req_b = '0;
      wait_until(s + 29);
      req = '0;
      wait_until(s + 36);

      // Lone requester 0, full length 16, waveform checked per count
      do_burst(0, 16, 16, 1'b1);
      // Length 0 and 31 both clamp to 16
      do_burst(2, 0, 16, 1'b0);
      do_burst(2, 31, 16, 1'b0);

      // Reset in the middle of a burst owned by requester 2
      s = cyc;
      req[2] = 1'b1;
      len[2*LW +: LW] = LW'(16);
      e.idx = 2;
      e.cyc = s + 1;
      gq.push_back(e);
      @(negedge clk);
      req = '0;
      wait_until(s + 7);
      check("pre_reset_out_high", 32'(out_pulse), 32'd1);
      rstn = 1'b0;
      #1;
      check("midrst_gnt", 32'(gnt), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_owner", 32'(owner), 32'd0);
      check("midrst_out_pulse", 32'(out_pulse), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      // After reset the pointer restarts at 0, so 1 beats 3
      s = cyc;
      req = 4'b1010;
      len = {NR{LW'(3)}};
      e.idx = 1;
      e.cyc = s + 1;
      gq.push_back(e);
      dq.push_back(s + 5);
      @(negedge clk);
      req = '0;
      wait_until(s + 9);

`ifdef PULSE_BURST_SCHED_ABORT_EN
      // Abort at count 6 of a 16-cycle burst
      s = cyc;
      req[0] = 1'b1;
      len[0 +: LW] = LW'(16);
      e.idx = 0;
      e.cyc = s + 1;
      gq.push_back(e);
      dq.push_back(s + 9);
      @(negedge clk);
      req = '0;
      wait_until(s + 8);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_out_low", 32'(out_pulse), 32'd0);
      check("abort_gap_busy", 32'(busy), 32'd1);
      @(negedge clk);
      check("abort_gap2_busy", 32'(busy), 32'd1);
      @(negedge clk);
      check("abort_idle", 32'(busy), 32'd0);
`endif

      repeat (4) @(negedge clk);
      check("grant_queue_drained", gq.size(), 32'd0);
      check("done_queue_drained", dq.size(), 32'd0);
      check("b_grant_queue_drained", gq_b.size(), 32'd0);
      check("b_done_queue_drained", dq_b.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
